// File: rtl/apple_spawn_ctrl.sv
// apple_spawn_ctrl
// Picks a conflict-free {x,y} apple position after each good collision.
// A fresh random sample is checked against the snake body, one segment per
// cycle. A conflict causes a resample. Once the random tries are used up,
// the candidate is stepped linearly instead. The committed position drives a
// registered per-pixel apple flag for the renderer.
//
// Start handshake: goodColl is a level from another timing domain. It is
// synchronised, and only its rising edge is turned into a one-cycle start
// pulse. That pulse is consumed in IDLE or FAIL and silently dropped in any
// busy state; nothing is queued.
module apple_spawn_ctrl #(
  parameter int MAX_LENGTH = 16,
  parameter int MAX_TRIES  = 4,
  localparam int LW = $clog2(MAX_LENGTH + 1),
  localparam int IW = (MAX_LENGTH > 1) ? $clog2(MAX_LENGTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          goodColl,
  input  logic [3:0]    randX,
  input  logic [3:0]    randY,
  input  logic [LW-1:0] body_len,
  output logic [IW-1:0] body_idx,
  input  logic [7:0]    body_seg,
  input  logic [3:0]    x,
  input  logic [3:0]    y,
  output logic          apple,
  output logic [7:0]    apple_cord,
  output logic          apple_valid,
  output logic          busy,
  output logic          spawn_done,
  output logic          spawn_fail,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SAMPLE = 3'd1,
    SCAN   = 3'd2,
    COMMIT = 3'd3,
    FAIL   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          sync0_q, sync1_q, start_q;
  logic [7:0]    cand_q, cand_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [3:0]    try_q, try_d;
  logic [7:0]    probe_q, probe_d;
  logic [7:0]    cord_q, cord_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic          apple_q;

  logic [LW-1:0] eff_len;
  logic          scan_last;
  logic          seg_hit;

  // Lengths beyond capacity are clamped; the length is read live, not latched.
  assign eff_len   = (body_len > LW'(MAX_LENGTH)) ? LW'(MAX_LENGTH) : body_len;
  assign scan_last = (LW'(idx_q) == (eff_len - LW'(1)));
  assign seg_hit   = (body_seg == cand_q);

  // Front end: two-flop synchroniser plus a registered rising-edge pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      sync0_q <= goodColl;
      sync1_q <= sync0_q;
      start_q <= sync0_q & ~sync1_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cand_q  <= 8'h00;
      idx_q   <= '0;
      try_q   <= 4'd0;
      probe_q <= 8'd0;
      cord_q  <= 8'hC5;
      valid_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      idx_q   <= idx_d;
      try_q   <= try_d;
      probe_q <= probe_d;
      cord_q  <= cord_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath update for the spawn sequence.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    idx_d   = idx_q;
    try_d   = try_q;
    probe_d = probe_q;
    cord_d  = cord_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_q) begin
          state_d = SAMPLE;
          valid_d = 1'b0;
          try_d   = 4'd0;
          probe_d = 8'd0;
        end
      end
      SAMPLE: begin
        cand_d  = {randX, randY};
        idx_d   = '0;
        state_d = (eff_len == '0) ? COMMIT : SCAN;
      end
      SCAN: begin
        if (seg_hit) begin
          if (try_q < 4'(MAX_TRIES - 1)) begin
            // Random tries remain: draw a new sample.
            try_d   = try_q + 4'd1;
            state_d = SAMPLE;
          end else if (probe_q == 8'hFF) begin
            state_d = FAIL;
          end else begin
            // Linear probe: step the candidate and rescan from segment 0.
            cand_d  = cand_q + 8'd1;
            idx_d   = '0;
            probe_d = probe_q + 8'd1;
          end
        end else if (scan_last) begin
          state_d = COMMIT;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      COMMIT: begin
        cord_d  = cand_q;
        valid_d = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      FAIL: begin
        valid_d = 1'b0;
        if (start_q) begin
          state_d = SAMPLE;
          try_d   = 4'd0;
          probe_d = 8'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered pixel compare; suppressed while no apple is placed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      apple_q <= 1'b0;
    end else begin
      apple_q <= valid_q && (cord_q == {x, y});
    end
  end

  assign body_idx    = (state_q == SCAN) ? idx_q : '0;
  assign apple       = apple_q;
  assign apple_cord  = cord_q;
  assign apple_valid = valid_q;
  assign spawn_done  = done_q;
  assign busy        = (state_q != IDLE) && (state_q != FAIL);
  assign spawn_fail  = (state_q == FAIL);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_apple_spawn_ctrl.sv
// Bench for apple_spawn_ctrl: directed scenarios plus randomized spawns,
// each checked against a cycle-level reference model built from the
// placement rules (sample, scan, resample cost, probe cost).
module tb_apple_spawn_ctrl;
  localparam int MAX_LENGTH = 16;
  localparam int MAX_TRIES  = 4;
  localparam int LW = 5;
  localparam int IW = 4;

  // Clock / reset block
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          goodColl = 1'b0;
  logic [3:0]    randX = 4'd0, randY = 4'd0, x = 4'd0, y = 4'd0;
  logic [LW-1:0] body_len = '0;
  logic [IW-1:0] body_idx;
  logic [7:0]    body_seg;
  logic          apple, apple_valid, busy, spawn_done, spawn_fail;
  logic [7:0]    apple_cord;
  logic [2:0]    dbg_state;

  logic [7:0] body_mem [0:15] = '{default: 8'h00};
  assign body_seg = body_mem[body_idx];

  apple_spawn_ctrl #(.MAX_LENGTH(MAX_LENGTH), .MAX_TRIES(MAX_TRIES)) dut (
    .clk(clk), .reset(reset), .goodColl(goodColl), .randX(randX), .randY(randY),
    .body_len(body_len), .body_idx(body_idx), .body_seg(body_seg), .x(x), .y(y),
    .apple(apple), .apple_cord(apple_cord), .apple_valid(apple_valid), .busy(busy),
    .spawn_done(spawn_done), .spawn_fail(spawn_fail), .dbg_state(dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit rand_rnd = 1'b0;
  int gc_left = 0;
  int sw_cyc = -1;
  logic [7:0] sw_val = 8'h00;
  logic [7:0] hist [int];
  logic [7:0] exp_q [$];

  initial begin
    #800000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: record the random value held this cycle, advance one clock,
  // then update stimulus for the new cycle.
  task automatic tick();
    hist[cyc] = {randX, randY};
    @(posedge clk);
    #2;
    if (gc_left > 0) begin
      gc_left--;
      if (gc_left == 0) goodColl = 1'b0;
    end
    if (rand_rnd) begin
      randX = 4'($urandom_range(0, 1));
      randY = 4'($urandom_range(0, 3));
    end
    if (cyc == sw_cyc) {randX, randY} = sw_val;
  endtask

  // Reference model. s0 is the cycle spent sampling. A scan starting at
  // cycle t that finds no conflict commits, with the result visible at
  // t+L+1. A conflict at index k resamples at t+k+1 (cost k+2) or, once the
  // random tries are used, rescans the next coordinate from t+k+1 (cost k+1).
  task automatic model(input int s0, input int L, output int done_c, output logic [7:0] cord);
    int s, scan_t, tries, k;
    logic [7:0] c;
    s = s0; c = hist[s]; scan_t = s + 1; tries = 0;
    done_c = -1; cord = c;
    for (int step = 0; step < 2000; step++) begin
      k = -1;
      for (int j = L - 1; j >= 0; j--) if (body_mem[j] == c) k = j;
      if (k < 0) begin
        done_c = scan_t + L + 1;
        cord = c;
        return;
      end
      if (tries < MAX_TRIES - 1) begin
        tries++;
        s = scan_t + k + 1;
        c = hist[s];
        scan_t = s + 1;
      end else begin
        c = c + 8'd1;
        scan_t = scan_t + k + 1;
      end
    end
  endtask

  task automatic run_spawn(input string tag, input int len, input int hold, input int rebump,
                           input int sw_rel, input int exp_rel, input int exp_cord, input int post);
    int g, dcyc, extra, eff, exp_d;
    logic [7:0] exp_c, q_c;
    bit seen;
    body_len = LW'(len);
    eff = (len > MAX_LENGTH) ? MAX_LENGTH : len;
    g = cyc;
    goodColl = 1'b1;
    gc_left = hold;
    sw_cyc = (sw_rel > 0) ? g + sw_rel : -1;
    seen = 1'b0;
    dcyc = 0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      tick();
      if (rebump > 0 && cyc == g + rebump) begin
        goodColl = 1'b1;
        gc_left = 2;
      end
      if (cyc == g + 3) begin
        check({tag, "_busy"}, busy, 1);
        check({tag, "_valid_low"}, apple_valid, 0);
      end
      if (spawn_done) begin
        seen = 1'b1;
        dcyc = cyc;
      end
    end
    check({tag, "_done_seen"}, seen, 1);
    if (seen) begin
      model(g + 3, eff, exp_d, exp_c);
      exp_q.push_back(exp_c);
      check({tag, "_done_cycle"}, dcyc, exp_d);
      q_c = exp_q.pop_front();
      check({tag, "_cord"}, apple_cord, q_c);
      check({tag, "_valid"}, apple_valid, 1);
      if (exp_rel >= 0) check({tag, "_latency"}, dcyc - (g + 2), exp_rel);
      if (exp_cord >= 0) check({tag, "_cord_const"}, apple_cord, exp_cord);
    end
    extra = 0;
    for (int i = 0; i < post; i++) begin
      tick();
      if (spawn_done) extra++;
    end
    check({tag, "_extra_done"}, extra, 0);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_idx_idle"}, body_idx, 0);
    sw_cyc = -1;
    goodColl = 1'b0;
    gc_left = 0;
  endtask

  initial begin
    int extra;
    // Reset values while reset is held
    #12;
    check("rst_cord", apple_cord, 8'hC5);
    check("rst_valid", apple_valid, 1);
    check("rst_apple", apple, 0);
    check("rst_busy", busy, 0);
    check("rst_done", spawn_done, 0);
    check("rst_fail", spawn_fail, 0);
    check("rst_idx", body_idx, 0);
    #1 reset = 1'b1;
    tick();
    tick();

    // Apple flag after reset
    x = 4'hC; y = 4'h5;
    tick();
    check("pix_c5_hit", apple, 1);
    x = 4'h3; y = 4'h5;
    tick();
    check("pix_35_miss", apple, 0);

    // Clean spawn, L=3
    body_mem[0] = 8'h11; body_mem[1] = 8'h22; body_mem[2] = 8'h33;
    randX = 4'h4; randY = 4'h4;
    run_spawn("clean3", 3, 1, 0, 0, 6, 8'h44, 4);
    x = 4'h4; y = 4'h4;
    tick();
    check("pix_44_hit", apple, 1);
    x = 4'hC; y = 4'h5;
    tick();
    check("pix_c5_gone", apple, 0);

    // One retry: 57 conflicts at index 1, second sample 6A
    body_mem[0] = 8'h11; body_mem[1] = 8'h57;
    randX = 4'h5; randY = 4'h7; sw_val = 8'h6A;
    run_spawn("retry", 2, 1, 0, 4, 8, 8'h6A, 4);

    // Random tries exhausted, then probing 11 -> 12 -> 13
    body_mem[0] = 8'h11; body_mem[1] = 8'h12;
    randX = 4'h1; randY = 4'h1;
    run_spawn("probe", 2, 1, 0, 0, 14, 8'h13, 4);

    // Long goodColl level: one spawn only
    body_mem[0] = 8'h11; body_mem[1] = 8'h22; body_mem[2] = 8'h33;
    randX = 4'h9; randY = 4'h9;
    run_spawn("hold20", 3, 20, 0, 0, 6, 8'h99, 25);

    // New rising edge while busy is dropped
    for (int i = 0; i < 10; i++) body_mem[i] = 8'hA0 + 8'(i);
    randX = 4'h7; randY = 4'h7;
    run_spawn("rebump", 10, 1, 4, 0, 13, 8'h77, 12);

    // Reset in the middle of a scan
    body_len = LW'(10);
    goodColl = 1'b1;
    gc_left = 1;
    for (int i = 0; i < 5; i++) tick();
    check("mid_scan_busy", busy, 1);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_cord", apple_cord, 8'hC5);
    check("mid_rst_valid", apple_valid, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", spawn_done, 0);
    check("mid_rst_apple", apple, 0);
    reset = 1'b1;
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (spawn_done) extra++;
    end
    check("mid_rst_no_done", extra, 0);

    // Empty body: commit the first sample 3 clocks after start
    rand_rnd = 1'b1;
    run_spawn("len0", 0, 1, 0, 0, 3, -1, 4);

    // Randomized spawns, including lengths above capacity
    for (int n = 0; n < 25; n++) begin
      for (int j = 0; j < 16; j++)
        body_mem[j] = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 3))};
      run_spawn("rnd", $urandom_range(0, 19), $urandom_range(1, 3), 0, 0, -1, -1, 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
